text_scan_controller: RTL and testbench

- Text-mode display sequencer that drives the character generator ROM. It is the requesting end of the generator's character/dot_count/scan_count → pixel interface.
- Scans a COLS x ROWS character buffer, owns the 4-bit-code text RAM (CPU-side write port) and generates raster timing.
- Issues character, dot and scan coordinates to the generator and realigns the returned pixel with hsync, vsync and active for the video output stage.

---
 rtl/text_video_pkg.sv | 22 ++
 rtl/text_scan_controller_if.sv | 28 ++
 rtl/text_ram.sv | 47 ++++
 rtl/text_scan_controller.sv | 191 +++++++++++++++++++
 tb/tb_text_scan_controller.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/text_video_pkg.sv
// Shared constants and types for the text-mode video path: cell geometry,
// character code width and the default 640x480 raster timing.
package text_video_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned CHAR_H = 16;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned DOT_W  = 3;   // log2(CHAR_W)
    localparam int unsigned SCAN_W = 4;   // log2(CHAR_H)

    localparam int unsigned DEF_COLS   = 80;
    localparam int unsigned DEF_ROWS   = 30;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    typedef logic [CODE_W-1:0] char_code_t;

endpackage

// File: rtl/text_scan_controller_if.sv
// Request/response bus between the scan controller and the character
// generator ROM. The controller is the master.
interface text_scan_controller_if;
    import text_video_pkg::*;

    logic                  gen_en;
    char_code_t            character;
    logic [DOT_W-1:0]      dot_count;
    logic [SCAN_W-1:0]     scan_count;
    logic                  pixel_in;

    modport master (
        output gen_en,
        output character,
        output dot_count,
        output scan_count,
        input  pixel_in
    );

    modport slave (
        input  gen_en,
        input  character,
        input  dot_count,
        input  scan_count,
        output pixel_in
    );

endinterface

// File: rtl/text_ram.sv
// Character-code RAM: one write port, one registered read port with
// read-before-write behaviour. Out-of-range writes are dropped. Only the
// read-data register is reset; stored contents survive reset.
module text_ram #(
    parameter  int unsigned DEPTH = 2400,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             wr_ok;

    // Qualify the write and select the next read data (hold when not reading).
    always_comb begin
        wr_ok   = we && ({1'b0, waddr} < (AW + 1)'(DEPTH));
        rdata_d = re ? mem_q[raddr] : rdata_q;
    end

    // Storage array; the read below samples the pre-write value on a collision.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/text_scan_controller.sv
// Text-mode raster sequencer. Stage 0 holds the h/v counters and issues the
// text RAM read; stage 1 presents code/dot/scan to the character generator;
// stage 2 aligns active and syncs with the generator's registered pixel.
// Every stage advances only on tick.
// Optional blinking underline cursor: define TEXT_CURSOR_EN.
module text_scan_controller
    import text_video_pkg::*;
#(
    parameter  int unsigned COLS   = DEF_COLS,
    parameter  int unsigned ROWS   = DEF_ROWS,
    parameter  int unsigned H_FP   = DEF_H_FP,
    parameter  int unsigned H_SYNC = DEF_H_SYNC,
    parameter  int unsigned H_BP   = DEF_H_BP,
    parameter  int unsigned V_FP   = DEF_V_FP,
    parameter  int unsigned V_SYNC = DEF_V_SYNC,
    parameter  int unsigned V_BP   = DEF_V_BP,
    localparam int unsigned AW     = $clog2(COLS * ROWS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  char_code_t             wr_char,
    text_scan_controller_if.master gen,
`ifdef TEXT_CURSOR_EN
    input  logic [AW-1:0]          cursor_addr,
    input  logic                   cursor_on,
`endif
    output logic                   vid_out,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   active
);

    localparam int unsigned H_ACT_N = COLS * CHAR_W;
    localparam int unsigned V_ACT_N = ROWS * CHAR_H;
    localparam int unsigned H_TOTAL = H_ACT_N + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACT_N + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT    = HW'(H_ACT_N);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACT_N + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACT_N + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACT_N);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACT_N + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACT_N + V_FP + V_SYNC - 1);

    // Stage 0
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_wrap, v_wrap;
    logic          act0, hp0, vp0;
    logic [AW-1:0] rd_addr;

    // Stage 1 (the character code register lives in the RAM)
    char_code_t        rd_data;
    logic [DOT_W-1:0]  dot1_q, dot1_d;
    logic [SCAN_W-1:0] scan1_q, scan1_d;
    logic              act1_q, act1_d;
    logic              hp1_q, hp1_d;
    logic              vp1_q, vp1_d;

    // Stage 2 (the pixel register lives in the generator)
    logic act2_q, act2_d;
    logic hp2_q, hp2_d;
    logic vp2_q, vp2_d;

`ifdef TEXT_CURSOR_EN
    logic [AW-1:0] addr1_q, addr1_d;
    logic [4:0]    frame_q, frame_d;
    logic          cur2_q, cur2_d;
`endif

    // Raster counters, visible-area and sync decode, RAM read address.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (tick) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
        end
        act0    = (h_q < H_ACT) && (v_q < V_ACT);
        hp0     = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        vp0     = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
        rd_addr = '0;
        if (act0) begin
            rd_addr = AW'(v_q[VW-1:SCAN_W]) * AW'(COLS) + AW'(h_q[HW-1:DOT_W]);
        end
    end

    // Pipeline next state: every stage holds while tick is low.
    always_comb begin
        dot1_d  = tick ? h_q[DOT_W-1:0]  : dot1_q;
        scan1_d = tick ? v_q[SCAN_W-1:0] : scan1_q;
        act1_d  = tick ? act0            : act1_q;
        hp1_d   = tick ? hp0             : hp1_q;
        vp1_d   = tick ? vp0             : vp1_q;
        act2_d  = tick ? act1_q          : act2_q;
        hp2_d   = tick ? hp1_q           : hp2_q;
        vp2_d   = tick ? vp1_q           : vp2_q;
    end

`ifdef TEXT_CURSOR_EN
    // Cursor: frame counter for blink phase, cell index carried to stage 2,
    // underline on the last two scan lines of the cursor cell.
    always_comb begin
        addr1_d = tick ? rd_addr : addr1_q;
        frame_d = (tick && h_wrap && v_wrap) ? frame_q + 1'b1 : frame_q;
        cur2_d  = cur2_q;
        if (tick) begin
            cur2_d = cursor_on && frame_q[4] && (addr1_q == cursor_addr)
                     && (scan1_q[SCAN_W-1:1] == 3'b111);
        end
    end
`endif

    // State registers with synchronous reset, independent of tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            dot1_q  <= '0;
            scan1_q <= '0;
            act1_q  <= 1'b0;
            hp1_q   <= 1'b0;
            vp1_q   <= 1'b0;
            act2_q  <= 1'b0;
            hp2_q   <= 1'b0;
            vp2_q   <= 1'b0;
`ifdef TEXT_CURSOR_EN
            addr1_q <= '0;
            frame_q <= '0;
            cur2_q  <= 1'b0;
`endif
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            dot1_q  <= dot1_d;
            scan1_q <= scan1_d;
            act1_q  <= act1_d;
            hp1_q   <= hp1_d;
            vp1_q   <= vp1_d;
            act2_q  <= act2_d;
            hp2_q   <= hp2_d;
            vp2_q   <= vp2_d;
`ifdef TEXT_CURSOR_EN
            addr1_q <= addr1_d;
            frame_q <= frame_d;
            cur2_q  <= cur2_d;
`endif
        end
    end

    text_ram #(
        .DEPTH (COLS * ROWS),
        .WIDTH (CODE_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_char),
        .re    (tick),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign gen.gen_en     = tick;
    assign gen.character  = rd_data;
    assign gen.dot_count  = dot1_q;
    assign gen.scan_count = scan1_q;

    // pixel_in is already the generator's stage-2 register; only gate it.
`ifdef TEXT_CURSOR_EN
    assign vid_out = (gen.pixel_in ^ cur2_q) & act2_q;
`else
    assign vid_out = gen.pixel_in & act2_q;
`endif
    assign active = act2_q;
    assign hsync  = ~hp2_q;
    assign vsync  = ~vp2_q;

endmodule

// File: tb/tb_text_scan_controller.sv
// Scoreboard bench for text_scan_controller on a reduced 4x3-cell raster
// (39 x 53 ticks per frame) with a behavioural character generator.
module tb_text_scan_controller;
    import text_video_pkg::*;

    localparam int unsigned COLS = 4, ROWS = 3;
    localparam int unsigned H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int unsigned V_FP = 2, V_SYNC = 2, V_BP = 1;
    // Hand-derived raster figures for the parameters above.
    localparam int H_ACT = 32, H_TOTAL = 39, V_ACT = 48, V_TOTAL = 53;
    localparam int HS_FIRST = 34, HS_LAST = 36, VS_FIRST = 50, VS_LAST = 51;
    localparam int DEPTH = 12, FRAME = 2067;

    typedef struct packed {
        logic [3:0] code;
        logic [2:0] dot;
        logic [3:0] scan;
    } gen_exp_t;

    typedef struct packed {
        logic vid;
        logic act;
        logic hs;
        logic vs;
    } vid_exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_char = '0;
    logic       vid_out, hsync, vsync, active;
    logic       pix_q = 1'b0;
`ifdef TEXT_CURSOR_EN
    logic [3:0] cursor_addr = '0;
    logic       cursor_on = 1'b0;
`endif

    text_scan_controller_if gen_if ();

    text_scan_controller #(
        .COLS(COLS), .ROWS(ROWS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_char     (wr_char),
        .gen         (gen_if),
`ifdef TEXT_CURSOR_EN
        .cursor_addr (cursor_addr),
        .cursor_on   (cursor_on),
`endif
        .vid_out     (vid_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active)
    );

    always #5 clk = ~clk;

    // Character generator font: any deterministic mix of code, dot and scan.
    function automatic logic gen_pix(logic [3:0] c, logic [2:0] d, logic [3:0] s);
        return c[d[1:0]] ^ d[2] ^ s[0];
    endfunction

    // Generator: registers its pixel one tick after the request.
    always @(posedge clk) begin
        if (gen_if.gen_en) pix_q <= gen_pix(gen_if.character, gen_if.dot_count,
                                            gen_if.scan_count);
    end
    assign gen_if.pixel_in = pix_q;

    gen_exp_t   q1[$];
    vid_exp_t   q2[$];
    logic [3:0] mem_m [DEPTH];
    int mh = 0, mv = 0;
    int checks = 0, errors = 0;
    int since_rst = 0, first_act = -1, first_hs = -1, first_vs = -1;
    int hs_low = 0, vs_low = 0, act_cnt = 0, seen7 = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(gen_exp_t g, vid_exp_t v);
        chk("character",  int'(gen_if.character),  int'(g.code));
        chk("dot_count",  int'(gen_if.dot_count),  int'(g.dot));
        chk("scan_count", int'(gen_if.scan_count), int'(g.scan));
        chk("vid_out", int'(vid_out), int'(v.vid));
        chk("active",  int'(active),  int'(v.act));
        chk("hsync",   int'(hsync),   int'(v.hs));
        chk("vsync",   int'(vsync),   int'(v.vs));
    endtask

    // Model the raster position consumed by the coming tick edge.
    task automatic push_model();
        gen_exp_t g;
        vid_exp_t v;
        logic     in_act;
        int       addr;
        logic [3:0] code;
        in_act = (mh < H_ACT) && (mv < V_ACT);
        addr   = in_act ? (mv / 16) * COLS + mh / 8 : 0;
        code   = mem_m[addr];
        g.code = code;
        g.dot  = 3'(mh % 8);
        g.scan = 4'(mv % 16);
        v.act  = in_act;
        v.vid  = gen_pix(code, g.dot, g.scan) & in_act;
        v.hs   = !(mh >= HS_FIRST && mh <= HS_LAST);
        v.vs   = !(mv >= VS_FIRST && mv <= VS_LAST);
        q1.push_back(g);
        q2.push_back(v);
        if (mh == H_TOTAL - 1) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    endtask

    task automatic step(logic t, logic we, logic [3:0] wa, logic [3:0] wc);
        @(negedge clk);
        rst_n = 1'b1; tick = t; wr_en = we; wr_addr = wa; wr_char = wc;
        if (t) push_model();
        if (we && int'(wa) < DEPTH) mem_m[wa] = wc;
    endtask

    task automatic do_reset(logic t, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0; tick = t; wr_en = 1'b0;
        end
        mh = 0;
        mv = 0;
    endtask

    task automatic run_to(int h, int v);
        for (int i = 0; i < 3 * FRAME && !(mh == h && mv == v); i++) step(1, 0, 0, 0);
        chk("reach_h", mh, h);
        chk("reach_v", mv, v);
    endtask

    task automatic check_frame_stats();
        chk("first_active_tick", first_act, 2);
        chk("first_hsync_low_tick", first_hs, 36);
        chk("first_vsync_low_tick", first_vs, 1952);
        chk("hsync_low_per_frame", hs_low, 159);
        chk("vsync_low_per_frame", vs_low, 78);
        chk("active_per_frame", act_cnt, 1536);
    endtask

    // Monitor: pops the scoreboard after each tick edge, checks holds otherwise.
    initial begin : monitor
        gen_exp_t glast, ge;
        vid_exp_t vlast, ve;
        logic t, r;
        glast = '0;
        vlast = '{vid: 1'b0, act: 1'b0, hs: 1'b1, vs: 1'b1};
        forever begin
            @(posedge clk);
            t = tick;
            r = rst_n;
            #1;
            if (!r) begin
                q1.delete();
                q2.delete();
                glast = '0;
                vlast = '{vid: 1'b0, act: 1'b0, hs: 1'b1, vs: 1'b1};
                q2.push_back(vlast);  // stage-2 bubble left by reset
                since_rst = 0; first_act = -1; first_hs = -1; first_vs = -1;
                hs_low = 0; vs_low = 0; act_cnt = 0;
                cmp_all(glast, vlast);
            end else if (t) begin
                chk("gen_en_high", int'(gen_if.gen_en), 1);
                if (q1.size() == 0 || q2.size() < 2) begin
                    chk("scoreboard_underflow", q1.size(), 1);
                end else begin
                    ge = q1.pop_front();
                    ve = q2.pop_front();
                    glast = ge;
                    vlast = ve;
                    cmp_all(ge, ve);
                end
                since_rst++;
                if (active && first_act < 0) first_act = since_rst;
                if (!hsync && first_hs < 0) first_hs = since_rst;
                if (!vsync && first_vs < 0) first_vs = since_rst;
                if (since_rst > 10 && since_rst <= 10 + FRAME) begin
                    hs_low += int'(!hsync);
                    vs_low += int'(!vsync);
                    act_cnt += int'(active);
                end
                if (gen_if.character == 4'd7) seen7++;
            end else begin
                chk("gen_en_low", int'(gen_if.gen_en), 0);
                cmp_all(glast, vlast);
            end
        end
    end

    initial begin : driver
        logic [3:0] codes [12];
        codes = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd6, 4'd8, 4'd10, 4'd11, 4'd12, 4'd13};
        do_reset(1'b0, 3);
        // Load the text RAM with tick low; the last two writes are out of range.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 4'(i), codes[i]);
        step(0, 1, 4'd12, 4'd7);
        step(0, 1, 4'd15, 4'd7);
        // One full frame with tick held high.
        for (int i = 0; i < FRAME + 40; i++) step(1, 0, 0, 0);
        check_frame_stats();
        // Rewrite a cell while it is being read (read-before-write).
        run_to(10, 20);
        step(1, 1, 4'd5, 4'd14);
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0);
        // Irregular tick pattern.
        for (int i = 0; i < 300; i++) step(i % 3 != 2, 0, 0, 0);
        // Mid-line stall of 50 clocks.
        run_to(17, 5);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0);
        // Reset mid-frame with tick high at the reset edge.
        run_to(20, 30);
        do_reset(1'b1, 1);
        for (int i = 0; i < FRAME + 40; i++) step(1, 0, 0, 0);
        check_frame_stats();
        chk("no_code_7_seen", seen7, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
